// File: rtl/aom_po_memory_if.sv
// Operand/PO-write bus of the Programmed Offset memory.
`timescale 1ns/1ps
interface aom_po_memory_if #(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned PO_ADDR_WIDTH  = 5,
   parameter int unsigned PO_ENTRY_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0]     raw_addr;
   logic                      indirect;
   logic                      abort;
   logic                      po_wren;
   logic [PO_ADDR_WIDTH-1:0]  po_write_addr;
   logic [PO_ENTRY_WIDTH-1:0] po_write_data;
   logic [ADDR_WIDTH-1:0]     programmed_offset;

   modport master (
      output raw_addr, indirect, abort, po_wren, po_write_addr, po_write_data,
      input  programmed_offset
   );

   modport slave (
      input  raw_addr, indirect, abort, po_wren, po_write_addr, po_write_data,
      output programmed_offset
   );
endinterface

// File: rtl/aom_po_memory.sv
// Programmed Offset memory: per-thread {incr, offset} table with delayed post-increment writeback.
// Define AOM_PO_INCR_SIGNED_EN to sign-extend the increment (allows post-decrement).
`timescale 1ns/1ps
module aom_po_memory #(
   parameter int unsigned ADDR_WIDTH         = 12,
   parameter int unsigned PO_INCR_WIDTH      = 4,
   parameter int unsigned PO_ADDR_WIDTH      = 5,
   parameter int unsigned PO_ENTRY_COUNT     = 32,
   parameter int unsigned PO_ENTRY_WIDTH     = 16,
   parameter string       PO_INIT_FILE       = "",
   parameter string       RAMSTYLE           = "",
   parameter bit          READ_NEW_DATA      = 1'b0,
   parameter int unsigned THREAD_COUNT       = 8,
   parameter int unsigned THREAD_COUNT_WIDTH = 3
) (
   input logic            clock,
   input logic            reset_n,
   aom_po_memory_if.slave bus
);
   localparam int unsigned IDX_WIDTH = PO_ADDR_WIDTH - THREAD_COUNT_WIDTH;
   localparam int unsigned DELAY     = THREAD_COUNT - 2;
   localparam int unsigned EXT_WIDTH = ADDR_WIDTH - PO_INCR_WIDTH;

   if (THREAD_COUNT < 3) begin : g_bad_thread_count
      $error("aom_po_memory: THREAD_COUNT must be at least 3");
   end

   if (PO_INIT_FILE != "" || RAMSTYLE != "") begin : g_impl_hints
      $info("aom_po_memory: preload '%s' and ram style '%s' are applied by the implementation flow",
            PO_INIT_FILE, RAMSTYLE);
   end

   logic [THREAD_COUNT_WIDTH-1:0] read_thread;
   logic [THREAD_COUNT_WIDTH-1:0] write_thread;

   logic [IDX_WIDTH-1:0]          rd_idx;
   logic [PO_ADDR_WIDTH-1:0]      rd_addr;
   logic [PO_ENTRY_WIDTH-1:0]     rd_entry;

   logic                          s1_indirect;
   logic [IDX_WIDTH-1:0]          s1_idx;
   logic                          s1_valid;
   logic [PO_INCR_WIDTH-1:0]      s1_incr;
   logic [ADDR_WIDTH-1:0]         s1_offset;
   logic [ADDR_WIDTH-1:0]         incr_ext;
   logic [ADDR_WIDTH-1:0]         new_offset;

   logic                          dl_valid [DELAY];
   logic [IDX_WIDTH-1:0]          dl_idx   [DELAY];
   logic [PO_ENTRY_WIDTH-1:0]     dl_data  [DELAY];

   logic                          wb_valid;
   logic                          wr_en;
   logic [PO_ADDR_WIDTH-1:0]      wr_addr;
   logic [PO_ENTRY_WIDTH-1:0]     wr_data;
   logic                          unused_raw_addr;

   (* ramstyle = RAMSTYLE *) logic [PO_ENTRY_WIDTH-1:0] mem [PO_ENTRY_COUNT];

   // Barrel thread counters; write_thread runs one ahead of read_thread.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         read_thread  <= '0;
         write_thread <= THREAD_COUNT_WIDTH'(1);
      end else begin
         read_thread  <= (read_thread == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) ?
                         '0 : read_thread + THREAD_COUNT_WIDTH'(1);
         write_thread <= (write_thread == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) ?
                         '0 : write_thread + THREAD_COUNT_WIDTH'(1);
      end
   end

   assign rd_idx          = bus.raw_addr[IDX_WIDTH-1:0];
   assign rd_addr         = {read_thread, rd_idx};
   assign unused_raw_addr = ^bus.raw_addr[ADDR_WIDTH-1:IDX_WIDTH];

   // Single write port: an external write always pre-empts the writeback.
   always_comb begin
      wr_en   = bus.po_wren | wb_valid;
      wr_addr = {write_thread, dl_idx[DELAY-1]};
      wr_data = dl_data[DELAY-1];
      if (bus.po_wren) begin
         wr_addr = bus.po_write_addr;
         wr_data = bus.po_write_data;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_entry    <= '0;
         s1_indirect <= 1'b0;
         s1_idx      <= '0;
      end else begin
         if (READ_NEW_DATA && wr_en && (wr_addr == rd_addr)) begin
            rd_entry <= wr_data;
         end else begin
            rd_entry <= mem[rd_addr];
         end
         s1_indirect <= bus.indirect;
         s1_idx      <= rd_idx;
      end
   end

   assign bus.programmed_offset = rd_entry[ADDR_WIDTH-1:0];

   assign s1_incr   = rd_entry[PO_ENTRY_WIDTH-1:ADDR_WIDTH];
   assign s1_offset = rd_entry[ADDR_WIDTH-1:0];
   assign s1_valid  = s1_indirect & ~bus.abort;

`ifdef AOM_PO_INCR_SIGNED_EN
   assign incr_ext = {{EXT_WIDTH{s1_incr[PO_INCR_WIDTH-1]}}, s1_incr};
`else
   assign incr_ext = {{EXT_WIDTH{1'b0}}, s1_incr};
`endif

   assign new_offset = s1_offset + incr_ext;

   // Writeback delay line lands the update on the cycle write_thread returns to the reader.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DELAY; i++) begin
            dl_valid[i] <= 1'b0;
         end
      end else begin
         dl_valid[0] <= s1_valid;
         for (int unsigned i = 1; i < DELAY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      dl_idx[0]  <= s1_idx;
      dl_data[0] <= {s1_incr, new_offset};
      for (int unsigned i = 1; i < DELAY; i++) begin
         dl_idx[i]  <= dl_idx[i-1];
         dl_data[i] <= dl_data[i-1];
      end
   end

   assign wb_valid = dl_valid[DELAY-1];
endmodule

// File: tb/tb_aom_po_memory.sv
// Directed bench for aom_po_memory: post-increment, abort, wrap, thread isolation, collisions, reset.
`timescale 1ns/1ps
module tb_aom_po_memory;
   logic clock = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   aom_po_memory_if #(.ADDR_WIDTH(12), .PO_ADDR_WIDTH(5), .PO_ENTRY_WIDTH(16)) bus ();

   aom_po_memory dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic idle_inputs();
      bus.raw_addr      = '0;
      bus.indirect      = 1'b0;
      bus.abort         = 1'b0;
      bus.po_wren       = 1'b0;
      bus.po_write_addr = '0;
      bus.po_write_data = '0;
   endtask

   // Leaves the bench at cycle 0: read_thread==0 for the inputs driven next.
   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      cyc = 0;
   endtask

   task automatic write_entry(input logic [4:0] a, input logic [15:0] d);
      bus.po_wren       = 1'b1;
      bus.po_write_addr = a;
      bus.po_write_data = d;
      tick();
      bus.po_wren = 1'b0;
   endtask

   task automatic setup_entry(input logic [4:0] a, input logic [15:0] d);
      do_reset();
      write_entry(a, d);
      do_reset();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      total++;
      if (bus.programmed_offset !== 12'h000) begin
         bad++;
         $display("FAIL reset_value: got %h want %h", bus.programmed_offset, 12'h000);
      end
   endtask

   task automatic test_post_increment();
      setup_entry(5'd1, 16'h2100);
      bus.raw_addr = 12'hA41;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL postinc_c1: got %h want %h", bus.programmed_offset, 12'h100);
      end
      run_to(8);
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      total++;
      if (bus.programmed_offset !== 12'h102) begin
         bad++;
         $display("FAIL postinc_c9: got %h want %h", bus.programmed_offset, 12'h102);
      end
      run_to(17);
      total++;
      if (bus.programmed_offset !== 12'h104) begin
         bad++;
         $display("FAIL postinc_c17: got %h want %h", bus.programmed_offset, 12'h104);
      end
   endtask

   task automatic test_abort_non_indirect();
      setup_entry(5'd1, 16'h2100);
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      bus.abort    = 1'b1;
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL abort_c1: got %h want %h", bus.programmed_offset, 12'h100);
      end
      tick();
      bus.abort = 1'b0;
      run_to(9);
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL abort_c9: got %h want %h", bus.programmed_offset, 12'h100);
      end
      run_to(17);
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL nonind_c17: got %h want %h", bus.programmed_offset, 12'h100);
      end
   endtask

   task automatic test_wrap();
      logic [11:0] exp_small;
      setup_entry(5'd1, 16'h1FFF);
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      total++;
      if (bus.programmed_offset !== 12'hFFF) begin
         bad++;
         $display("FAIL wrap_c1: got %h want %h", bus.programmed_offset, 12'hFFF);
      end
      run_to(9);
      total++;
      if (bus.programmed_offset !== 12'h000) begin
         bad++;
         $display("FAIL wrap_c9: got %h want %h", bus.programmed_offset, 12'h000);
      end
`ifdef AOM_PO_INCR_SIGNED_EN
      exp_small = 12'hFFF;
`else
      exp_small = 12'h00F;
`endif
      setup_entry(5'd1, 16'hF000);
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      total++;
      if (bus.programmed_offset !== 12'h000) begin
         bad++;
         $display("FAIL incr_f_c1: got %h want %h", bus.programmed_offset, 12'h000);
      end
      run_to(9);
      total++;
      if (bus.programmed_offset !== exp_small) begin
         bad++;
         $display("FAIL incr_f_c9: got %h want %h", bus.programmed_offset, exp_small);
      end
   endtask

   task automatic test_thread_isolation();
      logic [11:0] exp;
      do_reset();
      write_entry(5'd1, 16'h1100);
      write_entry(5'd5, 16'h1200);
      do_reset();
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k % 8 == 1) begin
            exp = 12'h100 + 12'((k - 1) / 8);
            total++;
            if (bus.programmed_offset !== exp) begin
               bad++;
               $display("FAIL iso_t0_c%0d: got %h want %h", k, bus.programmed_offset, exp);
            end
         end else if (k % 8 == 2) begin
            exp = 12'h200 + 12'((k - 2) / 8);
            total++;
            if (bus.programmed_offset !== exp) begin
               bad++;
               $display("FAIL iso_t1_c%0d: got %h want %h", k, bus.programmed_offset, exp);
            end
         end
      end
      bus.indirect = 1'b0;
   endtask

   task automatic test_write_collision();
      setup_entry(5'd1, 16'h1100);
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      run_to(7);
      write_entry(5'd1, 16'h1300);
      run_to(9);
      total++;
      if (bus.programmed_offset !== 12'h300) begin
         bad++;
         $display("FAIL collide_same_c9: got %h want %h", bus.programmed_offset, 12'h300);
      end
      // Different-address external write still drops the writeback.
      do_reset();
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      run_to(7);
      write_entry(5'd14, 16'h0555);
      run_to(9);
      total++;
      if (bus.programmed_offset !== 12'h300) begin
         bad++;
         $display("FAIL collide_diff_c9: got %h want %h", bus.programmed_offset, 12'h300);
      end
      bus.raw_addr = 12'h002;
      run_to(12);
      total++;
      if (bus.programmed_offset !== 12'h555) begin
         bad++;
         $display("FAIL collide_ext_c12: got %h want %h", bus.programmed_offset, 12'h555);
      end
   endtask

   task automatic test_reset_mid_operation();
      setup_entry(5'd1, 16'h1100);
      bus.raw_addr = 12'h001;
      bus.indirect = 1'b1;
      tick();
      bus.indirect = 1'b0;
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL rstmid_c1: got %h want %h", bus.programmed_offset, 12'h100);
      end
      run_to(4);
      reset_n = 1'b0;
      #1;
      total++;
      if (bus.programmed_offset !== 12'h000) begin
         bad++;
         $display("FAIL rstmid_async: got %h want %h", bus.programmed_offset, 12'h000);
      end
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      cyc = 0;
      tick();
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL rstmid_after: got %h want %h", bus.programmed_offset, 12'h100);
      end
      run_to(9);
      total++;
      if (bus.programmed_offset !== 12'h100) begin
         bad++;
         $display("FAIL rstmid_discard: got %h want %h", bus.programmed_offset, 12'h100);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_post_increment();
      test_abort_non_indirect();
      test_wrap();
      test_thread_isolation();
      test_write_collision();
      test_reset_mid_operation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
